ultrasonic_ranger_array: RTL
============================

# ultrasonic_ranger_array

Multi-channel controller for HC-SR04-style ultrasonic sensors. It fires CHANNELS sensors one at a time in round-robin order so their echoes cannot cross-talk, and measures each echo pulse directly in centimetres. Each channel's result is stored, and the block reports the nearest obstacle with a hysteresis proximity alarm. It sits between the sensor header pins and the display/buzzer logic and replaces single-sensor ranging.

## Interface
- CHANNELS, 4, number of sensors (1..8)
- CLKS_PER_US, 50, clock cycles per microsecond
- TRIG_US, 10, trigger pulse width in µs
- CLKS_PER_CM, 2900, clock cycles of echo-high per cm (58 µs × 50)
- MAX_CM, 400, saturation/timeout distance in cm
- RISE_TIMEOUT_US, 1000, max wait for echo rising edge after trigger
- HOLDOFF_US, 60000, quiet time after each measurement
- DIST_W, 9, distance width in bits (must hold MAX_CM)
- NEAR_CM, 30, alarm set threshold
- HYST_CM, 5, alarm release hysteresis
- clock  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- enable  in  1  run ranging; sampled only in IDLE
- echo  in  CHANNELS  raw echo inputs, asynchronous
- trig  out  CHANNELS  one-hot trigger outputs
- dist_valid  out  1  one-cycle strobe: new result on dist_chan/dist_cm
- dist_chan  out  $clog2(CHANNELS)  channel of latest result
- dist_cm  out  DIST_W  latest result
- dist_timeout  out  1  latest result was a timeout (qualified by dist_valid)
- dist_all  out  CHANNELS*DIST_W  per-channel stored distance, channel 0 in LSBs
- chan_seen  out  CHANNELS  channel has at least one result since reset
- min_cm  out  DIST_W  smallest stored distance among seen channels
- min_chan  out  $clog2(CHANNELS)  channel holding min_cm
- near  out  1  proximity alarm

## Operation
- Each echo bit passes through a 2-flop synchronizer; all FSM decisions use the synchronized value.
- A free-running µs tick pulses once every CLKS_PER_US cycles and paces TRIG, the rise timeout and HOLDOFF.
- FSM states:
  - IDLE: if enable, go to TRIG. Otherwise stay.
  - TRIG: trig[cur] high for exactly TRIG_US*CLKS_PER_US cycles, then go to WAIT_RISE.
  - WAIT_RISE: on synchronized echo high, clear the cm counter and prescaler and go to MEASURE. If RISE_TIMEOUT_US elapses first, record MAX_CM with timeout set and go to HOLDOFF.
  - MEASURE: the prescaler counts cycles while echo is high; each CLKS_PER_CM cycles, cm increments. When echo falls, record cm (floor; the partial cm is discarded). If cm reaches MAX_CM while echo is still high, record MAX_CM with timeout set.
  - HOLDOFF: wait HOLDOFF_US, advance cur (CHANNELS-1 wraps to 0), then go to IDLE.
- Recording a result:
  - store it into dist_all[cur] and set chan_seen[cur];
  - drive dist_chan, dist_cm and dist_timeout;
  - pulse dist_valid.
- Min tracking:
  - combinational scan of seen channels; on a tie the lowest index wins;
  - registered, so it updates one cycle after the store;
  - if no channel has been seen: min_cm=MAX_CM, min_chan=0.
- Alarm:
  - near sets when min_cm < NEAR_CM;
  - near clears when min_cm >= NEAR_CM+HYST_CM;
  - otherwise near holds its value.
  - Timeout results (MAX_CM) take part in min tracking as a normal distance.
- Dropping enable mid-cycle does not abort the cycle. The current channel completes through HOLDOFF, and the FSM then rests in IDLE.

## Timing
- Reset values:
  - trig=0, dist_valid=0, dist_timeout=0, dist_cm=0, dist_chan=0;
  - dist_all=0, chan_seen=0;
  - min_cm=MAX_CM, min_chan=0, near=0;
  - FSM=IDLE, cur=0, all counters 0.
- Asserting RESET mid-operation drops trig in the same cycle (asynchronous) and discards the in-flight measurement.
- IDLE→TRIG takes 1 cycle after enable is seen high. trig rises on the first TRIG cycle.
- Echo-to-FSM latency is 2 cycles (synchronizer).
- On the echo falling edge: dist_valid and dist_all update together, 1 cycle after the synchronized echo is seen low. min_cm/min_chan update 1 cycle later, and near updates 1 cycle after that.
- If echo falls in the same cycle that cm reaches MAX_CM, the result is MAX_CM with timeout=0.
- Echo activity outside WAIT_RISE/MEASURE, and on non-selected channels, is ignored.
- dist_valid is never high for two consecutive cycles.

## Test plan
- Basic 20 cm: CHANNELS=1, echo high 58000 cycles after trigger -> trig high 500 cycles, then dist_valid with dist_cm=20, dist_timeout=0, chan_seen=1.
- Floor rounding: echo high 2899 cycles -> dist_cm=0. Echo high 2900 cycles -> dist_cm=1.
- No echo: echo held low -> after 1000 µs, dist_cm=400, dist_timeout=1; the next trigger fires HOLDOFF_US later on the next channel.
- Stuck echo: echo held high -> dist_cm=400, dist_timeout=1 at exactly 400×2900 cycles after the rise.
- Round-robin and min: CHANNELS=4, distances 50/25/25/100 cm -> triggers on ch0,1,2,3,0 in order; min_cm=25, min_chan=1; near=1 after ch1; near stays 1 at 32 cm and clears at 35 cm.
- Reset mid-MEASURE: assert RESET while echo is high on ch2 -> trig=0 immediately, all outputs at reset values, no dist_valid; the first trigger after release is on ch0.

Source files
------------

// File: rtl/ultrasonic_ranger_array.sv
// Round-robin ultrasonic ranger: fires one sensor at a time and measures echo width in whole cm.
// Latency: result 3 cycles after raw echo falls (2 sync + 1 record); min 1 cycle later, near 1 after that.
// Backpressure: none; dist_valid is a single-cycle strobe the consumer must take when it fires.
//
// Ports: clock/RESET (async, active low); enable starts a ranging cycle from IDLE; echo[] raw sensor
// inputs; trig[] one-hot trigger pulses; dist_* latest result; dist_all/chan_seen per-channel store;
// min_cm/min_chan nearest stored distance; near hysteresis proximity alarm.
module ultrasonic_ranger_array #(
  parameter  int CHANNELS        = 4,
  parameter  int CLKS_PER_US     = 50,
  parameter  int TRIG_US         = 10,
  parameter  int CLKS_PER_CM     = 2900,  // must be >= 2
  parameter  int MAX_CM          = 400,
  parameter  int RISE_TIMEOUT_US = 1000,
  parameter  int HOLDOFF_US      = 60000,
  parameter  int DIST_W          = 9,
  parameter  int NEAR_CM         = 30,
  parameter  int HYST_CM         = 5,
  localparam int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clock,
  input  logic                       RESET,
  input  logic                       enable,
  input  logic [CHANNELS-1:0]        echo,
  output logic [CHANNELS-1:0]        trig,
  output logic                       dist_valid,
  output logic [CH_W-1:0]            dist_chan,
  output logic [DIST_W-1:0]          dist_cm,
  output logic                       dist_timeout,
  output logic [CHANNELS*DIST_W-1:0] dist_all,
  output logic [CHANNELS-1:0]        chan_seen,
  output logic [DIST_W-1:0]          min_cm,
  output logic [CH_W-1:0]            min_chan,
  output logic                       near
);

  localparam int TRIG_CYC = TRIG_US * CLKS_PER_US;
  localparam int TMR_MAX  = (TRIG_CYC > RISE_TIMEOUT_US)
                          ? ((TRIG_CYC > HOLDOFF_US) ? TRIG_CYC : HOLDOFF_US)
                          : ((RISE_TIMEOUT_US > HOLDOFF_US) ? RISE_TIMEOUT_US : HOLDOFF_US);
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int US_W     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int CPC_W    = $clog2(CLKS_PER_CM);

  localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0]  RISE_LAST = TMR_W'(RISE_TIMEOUT_US - 1);
  localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(HOLDOFF_US - 1);
  localparam logic [US_W-1:0]   US_LAST   = US_W'(CLKS_PER_US - 1);
  localparam logic [CPC_W-1:0]  CPC_LAST  = CPC_W'(CLKS_PER_CM - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CHANNELS - 1);
  localparam logic [DIST_W-1:0] MAX_D     = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0] NEAR_D    = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] CLEAR_D   = DIST_W'(NEAR_CM + HYST_CM);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_t;

  state_t              state;
  logic [CH_W-1:0]     cur;
  logic [TMR_W-1:0]    tmr;
  logic [DIST_W-1:0]   cm;
  logic [CPC_W-1:0]    cm_pre;
  logic [US_W-1:0]     us_pre;
  logic                us_tick;
  logic [CHANNELS-1:0] echo_m, echo_s;
  logic                echo_cur;
  logic                rec;
  logic [DIST_W-1:0]   rec_cm;
  logic                rec_to;
  logic [DIST_W-1:0]   scan_cm;
  logic [CH_W-1:0]     scan_ch;
  logic                scan_found;

  // Echo inputs are asynchronous to clock.
  always_ff @(posedge clock or negedge RESET) begin
    if (!RESET) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  // Free-running microsecond tick.
  always_ff @(posedge clock or negedge RESET) begin
    if (!RESET)       us_pre <= '0;
    else if (us_tick) us_pre <= '0;
    else              us_pre <= us_pre + 1'b1;
  end
  assign us_tick  = (us_pre == US_LAST);
  assign echo_cur = echo_s[cur];

  // Result decision. A count that has just reached MAX_CM is only a timeout if echo is still
  // high on the following cycle; a pulse of exactly MAX_CM cm reports MAX_CM without timeout.
  always_comb begin
    rec    = 1'b0;
    rec_cm = cm;
    rec_to = 1'b0;
    case (state)
      S_WAIT_RISE: if (!echo_cur && us_tick && tmr == RISE_LAST) begin
        rec    = 1'b1;
        rec_cm = MAX_D;
        rec_to = 1'b1;
      end
      S_MEASURE: if (!echo_cur) begin
        rec = 1'b1;
      end else if (cm == MAX_D) begin
        rec    = 1'b1;
        rec_cm = MAX_D;
        rec_to = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge RESET) begin
    if (!RESET) begin
      state        <= S_IDLE;
      cur          <= '0;
      tmr          <= '0;
      cm           <= '0;
      cm_pre       <= '0;
      trig         <= '0;
      dist_valid   <= 1'b0;
      dist_chan    <= '0;
      dist_cm      <= '0;
      dist_timeout <= 1'b0;
      dist_all     <= '0;
      chan_seen    <= '0;
    end else begin
      dist_valid <= 1'b0;
      if (rec) begin
        dist_all[cur*DIST_W +: DIST_W] <= rec_cm;
        chan_seen[cur]                 <= 1'b1;
        dist_chan                      <= cur;
        dist_cm                        <= rec_cm;
        dist_timeout                   <= rec_to;
        dist_valid                     <= 1'b1;
      end
      case (state)
        S_IDLE: if (enable) begin
          state <= S_TRIG;
          trig  <= CHANNELS'(1) << cur;
          tmr   <= '0;
        end
        // Trigger width is counted in cycles so it is exact regardless of tick phase.
        S_TRIG: if (tmr == TRIG_LAST) begin
          trig  <= '0;
          tmr   <= '0;
          state <= S_WAIT_RISE;
        end else begin
          tmr <= tmr + 1'b1;
        end
        S_WAIT_RISE: if (echo_cur) begin
          // The cycle that detects the rise is already the first echo-high cycle, so the
          // prescaler starts at one to keep each cm exactly CLKS_PER_CM cycles long.
          cm     <= '0;
          cm_pre <= CPC_W'(1);
          state  <= S_MEASURE;
        end else if (rec) begin
          tmr   <= '0;
          state <= S_HOLDOFF;
        end else if (us_tick) begin
          tmr <= tmr + 1'b1;
        end
        S_MEASURE: if (rec) begin
          tmr   <= '0;
          state <= S_HOLDOFF;
        end else if (cm_pre == CPC_LAST) begin
          cm_pre <= '0;
          cm     <= cm + 1'b1;
        end else begin
          cm_pre <= cm_pre + 1'b1;
        end
        S_HOLDOFF: if (us_tick) begin
          if (tmr == HOLD_LAST) begin
            tmr   <= '0;
            cur   <= (cur == LAST_CH) ? '0 : cur + 1'b1;
            state <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Nearest seen channel; strict compare keeps the lowest index on ties.
  always_comb begin
    scan_cm    = MAX_D;
    scan_ch    = '0;
    scan_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_seen[i] && (!scan_found || dist_all[i*DIST_W +: DIST_W] < scan_cm)) begin
        scan_cm    = dist_all[i*DIST_W +: DIST_W];
        scan_ch    = CH_W'(i);
        scan_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge RESET) begin
    if (!RESET) begin
      min_cm   <= MAX_D;
      min_chan <= '0;
      near     <= 1'b0;
    end else begin
      min_cm   <= scan_cm;
      min_chan <= scan_ch;
      if (min_cm < NEAR_D)        near <= 1'b1;
      else if (min_cm >= CLEAR_D) near <= 1'b0;
    end
  end

endmodule
